count_arb: RTL and testbench
============================

COUNT_ARB -- requirements
Module: count_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, setting the counter and run-length width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req0, input, 1 bit: requester 0 asks for a counting run.
REQ-005 The block SHALL have port req1, input, 1 bit: requester 1 asks for a counting run.
REQ-006 The block SHALL have port len0, input, WIDTH bits: requester 0 run length; 0 encodes 2^WIDTH.
REQ-007 The block SHALL have port len1, input, WIDTH bits: requester 1 run length; 0 encodes 2^WIDTH.
REQ-008 The block SHALL have port abort, input, 1 bit: terminates the current run.
REQ-009 The block SHALL have port gnt0, output, 1 bit: requester 0 owns the counter.
REQ-010 The block SHALL have port gnt1, output, 1 bit: requester 1 owns the counter.
REQ-011 The block SHALL have port cnt, output, WIDTH bits: shared counter value.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at run completion.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, with outputs registered.
REQ-015 In IDLE with a request pending, the block SHALL grant at the next edge, latch the winner's len and enter RUN.
REQ-016 Arbitration SHALL be round-robin: when req0 and req1 are both high, the requester not granted last wins.
REQ-017 When only one request is high, that requester SHALL win regardless of history.
REQ-018 In the first RUN cycle cnt SHALL equal the start value (REQ-034), then step by 1 per cycle, wrapping modulo 2^WIDTH.
REQ-019 RUN SHALL last exactly L cycles, where L is the latched length (1..2^WIDTH); then the FSM enters DONE.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle; cnt SHALL hold its last value; gnt SHALL remain high.
REQ-021 After DONE the FSM SHALL return to IDLE with gnt0=gnt1=0; cnt holds its last value.
REQ-022 A request SHALL be arbitrated only in IDLE, so back-to-back runs have at least one IDLE cycle between them.
REQ-023 Requesters MAY drop req after grant; the run SHALL complete unchanged.
REQ-024 Changes to len0/len1 after grant SHALL NOT affect the current run.
REQ-025 abort=1 in RUN SHALL force IDLE at the next edge: no done, gnt deasserted, cnt holds.
REQ-026 abort=1 in DONE or IDLE SHALL have no effect; abort SHALL take precedence over normal RUN completion on the same edge.
REQ-027 gnt0 and gnt1 SHALL never be high simultaneously.

Reset
REQ-028 While rst=1, outputs SHALL be forced immediately, independent of clk.
REQ-029 Reset values SHALL be: state=IDLE, gnt0=0, gnt1=0, busy=0, done=0, cnt=0, latched length=0.
REQ-030 Reset SHALL set the round-robin history so that requester 0 wins the first tie.
REQ-031 Reset asserted mid-run SHALL abandon the run with no done pulse.
REQ-032 After reset release, the first arbitration SHALL occur on the first rising edge with rst=0.

Configuration
REQ-033 Macro CNT_DOWN_EN SHALL select the count direction.
REQ-034 Without CNT_DOWN_EN: start value is 0 and cnt increments, ending at L-1.
REQ-035 With CNT_DOWN_EN: start value is L-1 (WIDTH bits, so 2^WIDTH-1 for len=0) and cnt decrements, ending at 0; all timing is identical in both builds.

Verification
REQ-036 Bench SHALL cover: reset, req0=1, len0=3, up build -> gnt0 next edge; cnt 0,1,2; done pulses once; busy low after DONE.
REQ-037 Bench SHALL cover: req0=req1=1 continuously, len=2 each -> grants alternate 0,1,0,1 with one IDLE cycle between runs.
REQ-038 Bench SHALL cover: len1=0, req1 only -> 32 RUN cycles, cnt 0..31 (down build 31..0), single done.
REQ-039 Bench SHALL cover: abort on the 2nd RUN cycle of a len=5 run -> IDLE next edge, no done, cnt frozen at 1.
REQ-040 Bench SHALL cover: rst pulsed mid-run at cnt=4 -> all outputs 0 without a clock edge; next tie goes to req0.
REQ-041 Bench SHALL cover: len0 changed from 6 to 2 one cycle after grant -> run still lasts 6 cycles.

Source files
------------

// File: rtl/count_arb.sv
// ----------------------------------------------------------------------------
// count_arb
//
// Two-requester round-robin arbiter that grants ownership of a shared counter
// for a run of L cycles (L = latched length, 0 encodes 2^WIDTH). A run goes
// IDLE -> RUN (L cycles) -> DONE (one cycle) -> IDLE. All outputs are
// registered.
//
// Build option:
//   CNT_DOWN_EN  defined   : counter starts at L-1 and counts down to 0
//                undefined : counter starts at 0 and counts up to L-1
//   Timing is identical in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req0/req1  in   requester 0/1 asks for a counting run
//   len0/len1  in   [WIDTH] run length for requester 0/1 (0 means 2^WIDTH)
//   abort      in   terminate the current run (effective only in RUN)
//   gnt0/gnt1  out  requester 0/1 owns the counter (RUN and DONE)
//   cnt        out  [WIDTH] shared counter value
//   busy       out  high in RUN and DONE
//   done       out  one-cycle pulse in DONE
// ----------------------------------------------------------------------------
module count_arb #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             abort,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic [WIDTH-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] len_q;   // latched run length
    logic [WIDTH-1:0] run_q;   // RUN cycles elapsed, minus one
    logic             last1_q; // 1: requester 1 was granted most recently

    logic             win1_d;
    logic [WIDTH-1:0] len_d;
    logic [WIDTH-1:0] start_d;
    logic [WIDTH-1:0] cnt_d;

    // On a tie the requester not granted last wins; a lone request always wins.
    always_comb begin
        win1_d = (req0 && req1) ? ~last1_q : req1;
        len_d  = win1_d ? len1 : len0;
`ifdef CNT_DOWN_EN
        start_d = len_d - ONE;   // len 0 wraps to 2^WIDTH-1
        cnt_d   = cnt_q - ONE;
`else
        start_d = '0;
        cnt_d   = cnt_q + ONE;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            run_q   <= '0;
            last1_q <= 1'b1;     // so requester 0 wins the first tie
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (req0 || req1) begin
                        state_q <= RUN;
                        gnt0_q  <= ~win1_d;
                        gnt1_q  <= win1_d;
                        busy_q  <= 1'b1;
                        len_q   <= len_d;
                        run_q   <= '0;
                        cnt_q   <= start_d;
                        last1_q <= win1_d;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (run_q == len_q - ONE) begin
                        // len_q of 0 compares against 2^WIDTH-1: full-length run
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        run_q <= run_q + ONE;
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign cnt  = cnt_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_count_arb.sv
// ----------------------------------------------------------------------------
// tb_count_arb
//
// Randomised and directed stimulus for count_arb. A reference model expands
// each grant into the full list of per-cycle outputs the run must produce
// (L RUN cycles, one DONE cycle, one IDLE cycle) and feeds them to a
// scoreboard queue; a monitor compares the DUT against that queue after
// every rising edge.
// ----------------------------------------------------------------------------
module tb_count_arb;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, abort;
    logic [W-1:0] len0, len1;
    logic         gnt0, gnt1, busy, done;
    logic [W-1:0] cnt;

    count_arb #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .len0 (len0),
        .len1 (len1),
        .abort(abort),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .cnt  (cnt),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         g0;
        logic         g1;
        logic [W-1:0] c;
        logic         busy;
        logic         done;
    } obs_t;

    obs_t sb_q[$];     // expected outputs, one per upcoming rising edge
    obs_t plan[$];     // remaining outputs of the run in progress
    obs_t cur;         // model outputs after the most recent edge
    int   last_owner;  // requester granted most recently
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t sample();
        obs_t o;
        o.g0   = gnt0;
        o.g1   = gnt1;
        o.c    = cnt;
        o.busy = busy;
        o.done = done;
        return o;
    endfunction

    function automatic obs_t mk(logic g0, logic g1, logic [W-1:0] c, logic b, logic d);
        obs_t o;
        o.g0 = g0; o.g1 = g1; o.c = c; o.busy = b; o.done = d;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got gnt0=%b gnt1=%b cnt=%0d busy=%b done=%b, expected gnt0=%b gnt1=%b cnt=%0d busy=%b done=%b",
                     name, $time, got.g0, got.g1, got.c, got.busy, got.done,
                     exp.g0, exp.g1, exp.c, exp.busy, exp.done);
        end
    endtask

    task automatic model_reset();
        plan.delete();
        cur        = '0;
        last_owner = 1;
    endtask

    // Predict outputs after the next edge given the inputs held across it.
    task automatic predict(input logic r0, input logic r1, input logic [W-1:0] l0,
                           input logic [W-1:0] l1, input logic ab, output obs_t nx);
        int w, L, v;
        if (plan.size() > 0) begin
            if (ab && cur.busy && !cur.done) begin
                plan.delete();
                nx = mk(1'b0, 1'b0, cur.c, 1'b0, 1'b0);
            end else begin
                nx = plan.pop_front();
            end
        end else if (r0 || r1) begin
            if (r0 && r1) w = (last_owner == 0) ? 1 : 0;
            else          w = r1 ? 1 : 0;
            last_owner = w;
            L = (w == 1) ? int'(l1) : int'(l0);
            if (L == 0) L = 1 << W;
            v = 0;
            for (int i = 0; i < L; i++) begin
`ifdef CNT_DOWN_EN
                v = L - 1 - i;
`else
                v = i;
`endif
                plan.push_back(mk(w == 0, w == 1, W'(v), 1'b1, 1'b0));
            end
            plan.push_back(mk(w == 0, w == 1, W'(v), 1'b1, 1'b1));
            plan.push_back(mk(1'b0, 1'b0, W'(v), 1'b0, 1'b0));
            nx = plan.pop_front();
        end else begin
            nx = mk(1'b0, 1'b0, cur.c, 1'b0, 1'b0);
        end
        cur = nx;
    endtask

    // One clock of stimulus: inputs change on the falling edge.
    task automatic cyc(input logic r0, input logic r1, input logic [W-1:0] l0,
                       input logic [W-1:0] l1, input logic ab);
        obs_t nx;
        @(negedge clk);
        rst   = 1'b0;
        req0  = r0;
        req1  = r1;
        len0  = l0;
        len1  = l1;
        abort = ab;
        predict(r0, r1, l0, l1, ab, nx);
        sb_q.push_back(nx);
    endtask

    // Reset asserted between edges: outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        abort = 1'b0;
        #1;
        check("async_reset", sample(), '0);
        model_reset();
        sb_q.push_back('0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, len0, len1, 1'b0);
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) check("cycle", sample(), sb_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d, expected 0", sb_q.size());
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] la, lb;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; abort = 1'b0;
        len0 = '0; len1 = '0;
        model_reset();
        do_reset();

        // single run, len 3
        cyc(1'b1, 1'b0, 5'd3, 5'd0, 1'b0);
        idle(6);

        // continuous tie, len 2 each: alternate grants
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 5'd2, 5'd2, 1'b0);
        idle(2);

        // full-length run (len 0)
        cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b0);
        idle(36);

        // abort on the second RUN cycle of a len 5 run
        cyc(1'b1, 1'b0, 5'd5, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 5'd5, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 5'd5, 5'd0, 1'b1);
        idle(3);

        // reset mid-run at cnt 4 (requester 0 owns), then tie goes to req0
        cyc(1'b1, 1'b0, 5'd9, 5'd0, 1'b0);
        idle(4);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 5'd2, 5'd2, 1'b0);
        idle(3);

        // length change after grant has no effect
        cyc(1'b1, 1'b0, 5'd6, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 5'd2, 5'd0, 1'b0);
        idle(9);

        // randomised traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                la = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(1, 4));
                lb = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(1, 4));
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), la, lb,
                    $urandom_range(0, 9) == 0);
            end
        end
        idle(40);

        @(posedge clk);
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: queue depth %0d, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
